// File: rtl/twiddle_seq.sv
// Twiddle-factor address sequencer for a 32-point radix-2 DIF FFT with a one-cycle ROM.
// Optional inverse (conjugate) tagging is enabled by defining TWIDDLE_SEQ_IFFT_EN.
module twiddle_seq #(
    parameter int NUM_STAGES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef TWIDDLE_SEQ_IFFT_EN
    input  logic       inverse,
    output logic       tw_conj,
`endif
    output logic       busy,
    output logic       done,
    output logic       rom_en,
    output logic [3:0] rom_addr,
    input  logic       tw_ready,
    output logic       tw_valid,
    output logic [2:0] tw_stage,
    output logic [3:0] tw_idx
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [2:0] LAST_S = 3'(NUM_STAGES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] s_q, s_d;
    logic [3:0] j_q, j_d;
    logic       tw_valid_q, tw_valid_d;
    logic [2:0] tw_stage_q, tw_stage_d;
    logic [3:0] tw_idx_q, tw_idx_d;
    logic       done_q, done_d;
    logic       issue;
`ifdef TWIDDLE_SEQ_IFFT_EN
    logic       conj_q, conj_d;
`endif

    // A new twiddle is fetched only when the output register is free or being drained.
    assign issue = (state_q == RUN) && (tw_ready || !tw_valid_q);

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        j_d        = j_q;
        tw_valid_d = tw_valid_q;
        tw_stage_d = tw_stage_q;
        tw_idx_d   = tw_idx_q;
        done_d     = 1'b0;
`ifdef TWIDDLE_SEQ_IFFT_EN
        conj_d     = conj_q;
`endif

        if (issue) begin
            tw_valid_d = 1'b1;
            tw_stage_d = s_q;
            tw_idx_d   = j_q;
        end else if (tw_valid_q && tw_ready) begin
            tw_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    s_d     = '0;
                    j_d     = '0;
`ifdef TWIDDLE_SEQ_IFFT_EN
                    conj_d  = inverse;
`endif
                end
            end
            RUN: begin
                if (issue) begin
                    if (j_q == 4'd15) begin
                        j_d = '0;
                        if (s_q == LAST_S) begin
                            state_d = DRAIN;
                            s_d     = '0;
                        end else begin
                            s_d = s_q + 3'd1;
                        end
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (tw_valid_q && tw_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            s_q        <= '0;
            j_q        <= '0;
            tw_valid_q <= 1'b0;
            tw_stage_q <= '0;
            tw_idx_q   <= '0;
            done_q     <= 1'b0;
`ifdef TWIDDLE_SEQ_IFFT_EN
            conj_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            j_q        <= j_d;
            tw_valid_q <= tw_valid_d;
            tw_stage_q <= tw_stage_d;
            tw_idx_q   <= tw_idx_d;
            done_q     <= done_d;
`ifdef TWIDDLE_SEQ_IFFT_EN
            conj_q     <= conj_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign rom_en   = issue;
    assign rom_addr = j_q << s_q;
    assign tw_valid = tw_valid_q;
    assign tw_stage = tw_stage_q;
    assign tw_idx   = tw_idx_q;
`ifdef TWIDDLE_SEQ_IFFT_EN
    assign tw_conj  = conj_q;
`endif

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq: a default 5-stage instance and a 1-stage instance,
// both checked against (s,j) sequences generated from plain loops and arithmetic.
module tb_twiddle_seq;
    localparam int NS    = 5;
    localparam int TOTAL = 16 * NS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic tw_ready = 1'b0;
    logic busy, done, rom_en, tw_valid;
    logic [3:0] rom_addr, tw_idx;
    logic [2:0] tw_stage;
`ifdef TWIDDLE_SEQ_IFFT_EN
    logic inverse = 1'b0;
    logic tw_conj;
    logic inverse1 = 1'b0;
    logic tw_conj1;
`endif

    logic start1 = 1'b0;
    logic rdy1 = 1'b0;
    logic busy1, done1, rom_en1, tw_valid1;
    logic [3:0] rom_addr1, tw_idx1;
    logic [2:0] tw_stage1;

    twiddle_seq #(.NUM_STAGES(NS)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef TWIDDLE_SEQ_IFFT_EN
        .inverse(inverse), .tw_conj(tw_conj),
`endif
        .busy(busy), .done(done), .rom_en(rom_en), .rom_addr(rom_addr),
        .tw_ready(tw_ready), .tw_valid(tw_valid), .tw_stage(tw_stage), .tw_idx(tw_idx)
    );

    twiddle_seq #(.NUM_STAGES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef TWIDDLE_SEQ_IFFT_EN
        .inverse(inverse1), .tw_conj(tw_conj1),
`endif
        .busy(busy1), .done(done1), .rom_en(rom_en1), .rom_addr(rom_addr1),
        .tw_ready(rdy1), .tw_valid(tw_valid1), .tw_stage(tw_stage1), .tw_idx(tw_idx1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected issue addresses and expected (stage*16 + idx) tags, in order.
    int exp_iss[$];
    int exp_acc[$];
    bit iss_open = 1'b0;
    bit pend_done = 1'b0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int exp_conj = 0;

    int iss1[$];
    int acc1[$];
    bit pend1 = 1'b0;
    int dcnt1 = 0;

    bit ready_mode = 1'b0;
    bit stall_req = 1'b0;
    bit stall_used = 1'b0;
    int stall_left = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
            tw_ready = 1'b0;
            stall_left--;
        end else if (stall_req && !stall_used && tw_valid && tw_stage == 3'd1 && tw_idx == 4'd5) begin
            stall_used = 1'b1;
            stall_left = 2;
            tw_ready   = 1'b0;
        end else begin
            tw_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        rdy1 = 1'($urandom_range(0, 1));
    end

    initial begin : mon
        bit exp_en;
        bit exp_busy;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("done", done, pend_done);
                pend_done = 1'b0;
                if (done) done_cnt++;
                exp_busy = iss_open && exp_acc.size() > 0;
                chk("busy", busy, exp_busy);
                exp_en = iss_open && exp_iss.size() > 0 && (tw_ready || !tw_valid);
                chk("rom_en", rom_en, exp_en);
                if (rom_en && exp_iss.size() > 0) chk("rom_addr", rom_addr, exp_iss.pop_front());
                if (tw_valid) begin
                    if (exp_acc.size() == 0) begin
                        chk("tw_valid_extra", tw_valid, 0);
                    end else begin
                        chk("tw_tag", {tw_stage, tw_idx}, exp_acc[0]);
`ifdef TWIDDLE_SEQ_IFFT_EN
                        chk("tw_conj", tw_conj, exp_conj);
`endif
                        if (tw_ready) begin
                            void'(exp_acc.pop_front());
                            acc_cnt++;
                            if (exp_acc.size() == 0) pend_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("n1_done", done1, pend1);
            pend1 = 1'b0;
            if (done1) dcnt1++;
            if (rom_en1) begin
                if (iss1.size() > 0) chk("n1_addr", rom_addr1, iss1.pop_front());
                else chk("n1_rom_en", rom_en1, 0);
            end
            if (tw_valid1) begin
                if (acc1.size() > 0) begin
                    chk("n1_tag", {tw_stage1, tw_idx1}, acc1[0]);
                    if (rdy1) begin
                        void'(acc1.pop_front());
                        if (acc1.size() == 0) pend1 = 1'b1;
                    end
                end else begin
                    chk("n1_valid_extra", tw_valid1, 0);
                end
            end
        end
    end

    int st_cyc = 0;

    task automatic do_start(input bit inv);
        iss_open = 1'b0;
        for (int s = 0; s < NS; s++)
            for (int j = 0; j < 16; j++) begin
                exp_iss.push_back((j * (1 << s)) % 16);
                exp_acc.push_back(s * 16 + j);
            end
        acc_cnt  = 0;
        done_cnt = 0;
        exp_conj = inv;
        @(posedge clk);
        #1;
        start = 1'b1;
`ifdef TWIDDLE_SEQ_IFFT_EN
        inverse = inv;
`endif
        st_cyc = cyc;
        @(posedge clk);
        iss_open = 1'b1;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        bit seen = 1'b0;
        dcyc = 0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
            end
        end
        chk("done_timeout", seen, 1);
    endtask

    task automatic wait_tag(input int s, input int j);
        bit found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(posedge clk);
            #1;
            if (tw_valid && tw_stage == 3'(s) && (j < 0 || tw_idx == 4'(j))) found = 1'b1;
        end
        chk("wait_tag_timeout", found, 1);
    endtask

    task automatic finish_seq();
        repeat (3) @(posedge clk);
        chk("acc_count", acc_cnt, TOTAL);
        chk("done_count", done_cnt, 1);
    endtask

    initial begin
        int dcyc;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_valid", tw_valid, 0);
        chk("rst_stage", tw_stage, 0);
        chk("rst_idx", tw_idx, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Constant ready: 80 accepts, done 82 cycles after start.
        do_start(1'b0);
        wait_done(300, dcyc);
        chk("done_latency", dcyc - st_cyc, 82);
        finish_seq();

        // Three-cycle stall on stage 1, index 5.
        stall_req = 1'b1;
        do_start(1'b0);
        wait_done(300, dcyc);
        chk("stall_seen", stall_used, 1);
        stall_req = 1'b0;
        finish_seq();

        // Random ready; start pulse while busy in stage 2 plus inverse toggling.
        ready_mode = 1'b1;
        do_start(1'b1);
        wait_tag(2, -1);
        start = 1'b1;
`ifdef TWIDDLE_SEQ_IFFT_EN
        inverse = 1'b0;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(800, dcyc);
        finish_seq();

        // Asynchronous reset mid-sequence aborts without done.
        do_start(1'b1);
        wait_tag(3, 7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_rom_en", rom_en, 0);
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_valid", tw_valid, 0);
        chk("arst_stage", tw_stage, 0);
        chk("arst_idx", tw_idx, 0);
`ifdef TWIDDLE_SEQ_IFFT_EN
        chk("arst_conj", tw_conj, 0);
`endif
        exp_iss.delete();
        exp_acc.delete();
        iss_open  = 1'b0;
        pend_done = 1'b0;
        done_cnt  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        chk("abort_no_done", done_cnt, 0);

        do_start(1'b0);
        wait_done(800, dcyc);
        finish_seq();

        // Single-stage instance with random ready: W0..W15 in order.
        for (int j = 0; j < 16; j++) begin
            iss1.push_back(j);
            acc1.push_back(j);
        end
        dcnt1 = 0;
        @(posedge clk);
        #1;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        begin
            bit seen1 = 1'b0;
            for (int k = 0; k < 300 && !seen1; k++) begin
                @(negedge clk);
                #1;
                if (done1) seen1 = 1'b1;
            end
            chk("n1_done_timeout", seen1, 1);
        end
        repeat (3) @(posedge clk);
        chk("n1_left_iss", iss1.size(), 0);
        chk("n1_left_acc", acc1.size(), 0);
        chk("n1_done_count", dcnt1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
